// File: rtl/instr_mem_loader_if.sv
// Program-load stream between a loader (bench, UART or debug master) and
// instr_mem_loader.
//   start      : single-cycle pulse that begins (or restarts) a program load
//   load_valid : loader presents load_data / load_last this cycle
//   load_ready : memory accepts a word this cycle
//   load_data  : 32-bit instruction word
//   load_last  : marks the final word of the program
// master = loader side, slave = memory side.
interface instr_mem_loader_if;
    logic        start;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic        load_last;

    modport master (
        output start,
        output load_valid,
        output load_data,
        output load_last,
        input  load_ready
    );

    modport slave (
        input  start,
        input  load_valid,
        input  load_data,
        input  load_last,
        output load_ready
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory for the Riscv core with a streaming program-load port.
// Holds the core in reset while a program loads, tracks the program length
// and either requests a PC wrap to 0 (WRAP_MODE=1) or feeds NOPs and flags
// halted (WRAP_MODE=0) once fetch runs past the last loaded word.
//   clk          : clock, rising edge
//   reset        : asynchronous, active-high reset
//   ld           : program-load stream (slave side)
//   instr_addr   : byte fetch address from the core
//   instr        : fetched word, combinational from instr_addr
//   core_reset   : registered reset to the core
//   pc_redirect  : asks the core to take PC = 0 (WRAP_MODE=1)
//   halted       : sticky, fetch passed program end (WRAP_MODE=0)
//   prog_len     : number of loaded words
//   misalign_err : sticky, misaligned fetch seen while running
module instr_mem_loader #(
    parameter int unsigned DEPTH     = 256,
    parameter bit          WRAP_MODE = 1'b1,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    instr_mem_loader_if.slave   ld,
    input  logic [31:0]         instr_addr,
    output logic [31:0]         instr,
    output logic                core_reset,
    output logic                pc_redirect,
    output logic                halted,
    output logic [AW:0]         prog_len,
    output logic                misalign_err
);

    localparam logic [AW:0] LEN_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LEN_LAST = (AW+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [AW:0] len_next;
    logic        core_reset_d;
    logic        halted_d;
    logic        misalign_d;

    logic [31:0] mem [DEPTH];

    logic        handshake;
    logic        wr_en;
    logic        past_end;
    logic [31:0] len_bytes;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;

    // prog_len doubles as the write pointer: it always equals the number of
    // words written so far in the current load.
    assign wr_idx    = prog_len[AW-1:0];
    assign rd_idx    = instr_addr[AW+1:2];
    assign len_bytes = 32'(prog_len) << 2;
    // Because prog_len <= DEPTH, this full-width compare also covers any
    // nonzero address bits above the word index.
    assign past_end  = (instr_addr >= len_bytes);
    assign handshake = ld.load_valid & ld.load_ready;
    // start takes priority: a word offered in the same cycle is dropped.
    assign wr_en     = (state == S_LOAD) && handshake && !ld.start;

    // State register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            prog_len     <= '0;
            core_reset   <= 1'b1;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_next;
            prog_len     <= len_next;
            core_reset   <= core_reset_d;
            halted       <= halted_d;
            misalign_err <= misalign_d;
        end
    end

    // Memory array, not cleared by reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= ld.load_data;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        len_next   = prog_len;
        case (state)
            S_IDLE: begin
                if (ld.start) begin
                    state_next = S_LOAD;
                    len_next   = '0;
                end
            end
            S_LOAD: begin
                if (ld.start) begin
                    len_next = '0;
                end else if (handshake) begin
                    len_next = prog_len + (AW+1)'(1);
                    // Filling the last slot ends the load just like load_last.
                    if (ld.load_last || (prog_len == LEN_LAST)) begin
                        state_next = S_RUN;
                    end
                end else if (prog_len >= LEN_FULL) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (ld.start) begin
                    state_next = S_LOAD;
                    len_next   = '0;
                end
            end
            default: begin
                state_next = S_IDLE;
                len_next   = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        ld.load_ready = (state == S_LOAD) && (prog_len < LEN_FULL);

        // Released only after a full cycle spent in RUN; reasserted on the
        // same edge that leaves RUN.
        core_reset_d = (state != S_RUN) || (state_next != S_RUN);

        if ((state == S_RUN) && !past_end) begin
            instr = mem[rd_idx];
        end else begin
            instr = NOP_INSTR;
        end

        pc_redirect = WRAP_MODE && (state == S_RUN) && past_end;

        halted_d = halted;
        if (ld.start) begin
            halted_d = 1'b0;
        end else if (!WRAP_MODE && (state == S_RUN) && past_end) begin
            halted_d = 1'b1;
        end

        misalign_d = misalign_err;
        if (ld.start) begin
            misalign_d = 1'b0;
        end else if ((state == S_RUN) && (instr_addr[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
        end
    end

endmodule
